// File: rtl/multicycle_cont_unit_if.sv
// Handshake and strobe bundle between the multicycle control unit and its datapath.
// The slave modport is the control unit; the master modport is the datapath/memory side.
interface multicycle_cont_unit_if;
  logic [31:0] inst;
  logic        mem_ready;
  logic        resume;
  logic        ir_write;
  logic        pc_write;
  logic        branch;
  logic        ebreak_signal;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  memToReg;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic        regWrite;
  logic        mem_err;
  logic [2:0]  state;

  modport slave (
    input  inst, mem_ready, resume,
    output ir_write, pc_write, branch, ebreak_signal, memRead, memWrite,
           memToReg, ALUOp, ALUSrc, regWrite, mem_err, state
  );

  modport master (
    output inst, mem_ready, resume,
    input  ir_write, pc_write, branch, ebreak_signal, memRead, memWrite,
           memToReg, ALUOp, ALUSrc, regWrite, mem_err, state
  );
endinterface

// File: rtl/multicycle_cont_unit.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with EBREAK halt and a
// memory-wait watchdog that parks the core in ERROR until reset.
module multicycle_cont_unit #(
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_cont_unit_if.slave bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StError  = 3'd6
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // {funct3, inst[20]} pattern identifying EBREAK within SYSTEM
  localparam logic [3:0] SysEbreak = 4'b0001;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_nxt;
  logic [6:0]           r_op;
  logic [3:0]           r_sys;

  logic       w_timeout;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_ebreak;
  logic       w_mem_read;
  logic       w_mem_write;
  logic [2:0] w_mem_to_reg;
  logic [1:0] w_alu_op;
  logic       w_alu_src;
  logic       w_reg_write;
  logic       w_mem_err;

  // Instruction fields not needed for control decoding
  logic w_unused_inst;
  assign w_unused_inst = ^{bus.inst[31:21], bus.inst[19:15], bus.inst[11:7]};

  assign w_timeout = (r_cnt == {TIMEOUT_W{1'b1}});

  // State, wait counter and decoded-field registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFetch;
      r_cnt   <= '0;
      r_op    <= '0;
      r_sys   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == StDecode) begin
        r_op  <= bus.inst[6:0];
        r_sys <= {bus.inst[14:12], bus.inst[20]};
      end
    end
  end

  // Next-state and per-state strobes; a ready in the timeout cycle still completes
  always_comb begin
    w_state_nxt  = r_state;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_ebreak     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 3'b000;
    w_alu_op     = 2'b00;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_err    = 1'b0;

    unique case (r_state)
      StFetch: begin
        w_mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write  = 1'b1;
          w_state_nxt = StDecode;
        end else if (w_timeout) begin
          w_state_nxt = StError;
        end
      end

      StDecode: w_state_nxt = StExec;

      StExec: begin
        case (r_op)
          OpLoad, OpStore: begin
            w_alu_src   = 1'b1;
            w_state_nxt = StMem;
          end
          OpLui, OpAuipc, OpJalr: begin
            w_alu_src   = 1'b1;
            w_state_nxt = StWb;
          end
          OpJal: begin
            w_alu_op    = 2'b10;
            w_alu_src   = 1'b1;
            w_state_nxt = StWb;
          end
          OpBranch: begin
            w_alu_op    = 2'b01;
            w_branch    = 1'b1;
            w_pc_write  = 1'b1;
            w_state_nxt = StFetch;
          end
          OpImm: begin
            w_alu_op    = 2'b11;
            w_alu_src   = 1'b1;
            w_state_nxt = StWb;
          end
          OpReg: begin
            w_alu_op    = 2'b10;
            w_state_nxt = StWb;
          end
          OpSystem: begin
            if (r_sys == SysEbreak) begin
              w_state_nxt = StHalt;
            end else begin
              w_pc_write  = 1'b1;
              w_state_nxt = StFetch;
            end
          end
          // FENCE and unknown opcodes retire as no-ops
          default: begin
            w_pc_write  = 1'b1;
            w_state_nxt = StFetch;
          end
        endcase
      end

      StMem: begin
        w_alu_src = 1'b1;
        if (r_op == OpLoad) begin
          w_mem_read = 1'b1;
        end else begin
          w_mem_write = 1'b1;
        end
        if (bus.mem_ready) begin
          if (r_op == OpLoad) begin
            w_state_nxt = StWb;
          end else begin
            w_pc_write  = 1'b1;
            w_state_nxt = StFetch;
          end
        end else if (w_timeout) begin
          w_state_nxt = StError;
        end
      end

      StWb: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        case (r_op)
          OpLoad:        w_mem_to_reg = 3'b001;
          OpLui:         w_mem_to_reg = 3'b010;
          OpAuipc:       w_mem_to_reg = 3'b011;
          OpJal, OpJalr: begin
            w_mem_to_reg = 3'b100;
            w_branch     = 1'b1;
          end
          default:       w_mem_to_reg = 3'b000;
        endcase
        w_state_nxt = StFetch;
      end

      StHalt: begin
        w_ebreak = 1'b1;
        if (bus.resume) begin
          w_pc_write  = 1'b1;
          w_state_nxt = StFetch;
        end
      end

      StError: w_mem_err = 1'b1;

      default: w_state_nxt = StFetch;
    endcase
  end

  // Wait counter clears on every state change and counts unanswered memory cycles
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (((r_state == StFetch) || (r_state == StMem)) && !bus.mem_ready) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Outputs are forced low while reset is held
  assign bus.ir_write      = w_ir_write & ~rst;
  assign bus.pc_write      = w_pc_write & ~rst;
  assign bus.branch        = w_branch & ~rst;
  assign bus.ebreak_signal = w_ebreak & ~rst;
  assign bus.memRead       = w_mem_read & ~rst;
  assign bus.memWrite      = w_mem_write & ~rst;
  assign bus.memToReg      = rst ? 3'b000 : w_mem_to_reg;
  assign bus.ALUOp         = rst ? 2'b00 : w_alu_op;
  assign bus.ALUSrc        = w_alu_src & ~rst;
  assign bus.regWrite      = w_reg_write & ~rst;
  assign bus.mem_err       = w_mem_err & ~rst;
  assign bus.state         = rst ? 3'd0 : r_state;

endmodule

// File: tb/tb_multicycle_cont_unit.sv
// Scoreboarded bench for multicycle_cont_unit: each scenario queues per-cycle stimulus
// with the expected output vector, then replays and compares at the falling edge.
module tb_multicycle_cont_unit;

  logic clk;
  logic rst;

  multicycle_cont_unit_if bus ();

  multicycle_cont_unit #(.TIMEOUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {state, ir_write, pc_write, branch, ebreak, memRead, memWrite, memToReg, ALUOp, ALUSrc,
  //  regWrite, mem_err}
  logic [16:0] w_out;
  assign w_out = {bus.state, bus.ir_write, bus.pc_write, bus.branch, bus.ebreak_signal,
                  bus.memRead, bus.memWrite, bus.memToReg, bus.ALUOp, bus.ALUSrc,
                  bus.regWrite, bus.mem_err};

  typedef struct packed {
    logic        rst;
    logic [31:0] inst;
    logic        mr;
    logic        res;
  } stim_t;

  stim_t       stim_q[$];
  logic [16:0] exp_q[$];
  logic [31:0] cur_inst;
  int          checks;
  int          errors;

  function automatic logic [16:0] pk(input logic [2:0] st, input logic irw, input logic pcw,
                                     input logic br, input logic eb, input logic mrd,
                                     input logic mwr, input logic [2:0] m2r,
                                     input logic [1:0] aop, input logic asrc, input logic rw,
                                     input logic err);
    return {st, irw, pcw, br, eb, mrd, mwr, m2r, aop, asrc, rw, err};
  endfunction

  function automatic logic [16:0] e_fetch(input logic irw);
    return pk(3'd0, irw, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_dec();
    return pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_exec(input logic [1:0] aop, input logic asrc,
                                         input logic br, input logic pcw);
    return pk(3'd2, 1'b0, pcw, br, 1'b0, 1'b0, 1'b0, 3'b000, aop, asrc, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_mem(input logic rd, input logic wr, input logic pcw);
    return pk(3'd3, 1'b0, pcw, 1'b0, 1'b0, rd, wr, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_wb(input logic [2:0] m2r, input logic br);
    return pk(3'd4, 1'b0, 1'b1, br, 1'b0, 1'b0, 1'b0, m2r, 2'b00, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] e_halt(input logic pcw);
    return pk(3'd5, 1'b0, pcw, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] e_err();
    return pk(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1);
  endfunction

  // Queue one cycle of stimulus together with the outputs expected in that cycle
  task automatic cyc(input logic r, input logic mr, input logic res, input logic [16:0] e);
    stim_q.push_back({r, cur_inst, mr, res});
    exp_q.push_back(e);
  endtask

  // Fetch completing immediately, then decode
  task automatic fetch_decode();
    cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc(1'b0, 1'b0, 1'b0, e_dec());
  endtask

  // Apply the next queued stimulus just after the rising edge; return at the falling edge
  task automatic drive_cycle();
    stim_t s;
    @(posedge clk);
    #1;
    s = stim_q.pop_front();
    rst           = s.rst;
    bus.inst      = s.inst;
    bus.mem_ready = s.mr;
    bus.resume    = s.res;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0000_0000;
    cyc(1'b1, 1'b1, 1'b1, 17'd0);
    cyc(1'b1, 1'b0, 1'b0, 17'd0);
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc(1'b0, 1'b1, 1'b0, e_dec());
    // opcode 0 is unknown: single pc_write, back to fetch
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b00, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_rtype();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0020_81B3;
    fetch_decode();
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b10, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, e_wb(3'b000, 1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL rtype cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_load();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0000_A103;
    fetch_decode();
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b00, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, e_mem(1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, e_wb(3'b001, 1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL load cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_store();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0020_A023;
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    fetch_decode();
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b00, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b1, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, e_mem(1'b0, 1'b1, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL store cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0020_8463;
    fetch_decode();
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b01, 1'b0, 1'b1, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL branch cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_ebreak();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0010_0073;
    fetch_decode();
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b00, 1'b0, 1'b0, 1'b0));
    // mem_ready toggling must not disturb HALT
    for (int i = 0; i < 10; i++) cyc(1'b0, i[0], 1'b0, e_halt(1'b0));
    cyc(1'b0, 1'b0, 1'b1, e_halt(1'b1));
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL ebreak cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts[8];
    logic [16:0] ex[8];
    logic [16:0] wv[8];
    logic        has_wb[8];
    logic [16:0] e;
    int n;
    insts[0] = 32'h0080_00EF; ex[0] = e_exec(2'b10, 1'b1, 1'b0, 1'b0);
    wv[0] = e_wb(3'b100, 1'b1); has_wb[0] = 1'b1;
    insts[1] = 32'h1234_50B7; ex[1] = e_exec(2'b00, 1'b1, 1'b0, 1'b0);
    wv[1] = e_wb(3'b010, 1'b0); has_wb[1] = 1'b1;
    insts[2] = 32'h0000_1097; ex[2] = e_exec(2'b00, 1'b1, 1'b0, 1'b0);
    wv[2] = e_wb(3'b011, 1'b0); has_wb[2] = 1'b1;
    insts[3] = 32'h0010_8093; ex[3] = e_exec(2'b11, 1'b1, 1'b0, 1'b0);
    wv[3] = e_wb(3'b000, 1'b0); has_wb[3] = 1'b1;
    insts[4] = 32'h0000_80E7; ex[4] = e_exec(2'b00, 1'b1, 1'b0, 1'b0);
    wv[4] = e_wb(3'b100, 1'b1); has_wb[4] = 1'b1;
    insts[5] = 32'h0000_000F; ex[5] = e_exec(2'b00, 1'b0, 1'b0, 1'b1);
    wv[5] = 17'd0; has_wb[5] = 1'b0;
    insts[6] = 32'h0000_0073; ex[6] = e_exec(2'b00, 1'b0, 1'b0, 1'b1);
    wv[6] = 17'd0; has_wb[6] = 1'b0;
    // SYSTEM with inst[20]=1 but funct3!=0 is not EBREAK
    insts[7] = 32'h0010_1073; ex[7] = e_exec(2'b00, 1'b0, 1'b0, 1'b1);
    wv[7] = 17'd0; has_wb[7] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cur_inst = insts[k];
      fetch_decode();
      cyc(1'b0, 1'b0, 1'b0, ex[k]);
      if (has_wb[k]) cyc(1'b0, 1'b0, 1'b0, wv[k]);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_fetch_timeout();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0020_81B3;
    cyc(1'b1, 1'b0, 1'b0, 17'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    cyc(1'b0, 1'b1, 1'b0, e_err());
    cyc(1'b0, 1'b0, 1'b1, e_err());
    cyc(1'b0, 1'b1, 1'b1, e_err());
    cyc(1'b1, 1'b0, 1'b0, 17'd0);
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL fetch_timeout cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_timeout_edge();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0020_81B3;
    cyc(1'b1, 1'b0, 1'b0, 17'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    // ready in the last permitted cycle completes normally
    cyc(1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc(1'b0, 1'b0, 1'b0, e_dec());
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b10, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, e_wb(3'b000, 1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL timeout_edge cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_mem_timeout();
    logic [16:0] e;
    int n;
    cur_inst = 32'h0000_A103;
    fetch_decode();
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b00, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, e_err());
    cyc(1'b1, 1'b0, 1'b0, 17'd0);
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL mem_timeout cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] e;
    int n;
    // Abandon a load in EXEC via an asynchronous reset asserted mid-cycle
    cur_inst = 32'h0000_A103;
    fetch_decode();
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b00, 1'b1, 1'b0, 1'b0));
    n = 0;
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (w_out !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid async: got %h expected %h", w_out, 17'd0);
    end
    cyc(1'b1, 1'b1, 1'b0, 17'd0);
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    // Reset out of HALT
    cur_inst = 32'h0010_0073;
    fetch_decode();
    cyc(1'b0, 1'b0, 1'b0, e_exec(2'b00, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, e_halt(1'b0));
    cyc(1'b1, 1'b0, 1'b1, 17'd0);
    cyc(1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    while (exp_q.size() > 0) begin
      drive_cycle();
      e = exp_q.pop_front();
      checks++;
      if (w_out !== e) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", n, w_out, e);
      end
      n++;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.inst      = 32'h0;
    bus.mem_ready = 1'b0;
    bus.resume    = 1'b0;
    cur_inst      = 32'h0;
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch();
    test_ebreak();
    test_back_to_back();
    test_fetch_timeout();
    test_timeout_edge();
    test_mem_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_cont_unit.md
MULTICYCLE_CONT_UNIT -- requirements
Module: multicycle_cont_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 4, width of the memory-wait counter; timeout limit = 2^TIMEOUT_W-1 cycles.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-003 inst  in  32  instruction register contents, stable from DECODE onward.
REQ-004 mem_ready  in  1  memory completes current access this cycle.
REQ-005 resume  in  1  leave HALT.
REQ-006 ir_write  out  1  load instruction register; pc_write  out  1  update PC.
REQ-007 branch  out  1  PC mux selects branch/jump target; ebreak_signal  out  1  core halted.
REQ-008 memRead, memWrite  out  1 each  memory access strobes.
REQ-009 memToReg  out  3  RF write source: 000 ALU, 001 memory, 010 immediate, 011 PC+imm, 100 PC+4.
REQ-010 ALUOp  out  2  (00 add, 01 branch compare, 10 R-type/JAL, 11 I-type); ALUSrc  out  1  ALU operand B = immediate.
REQ-011 regWrite  out  1; mem_err  out  1  sticky memory timeout; state  out  3  current FSM state.

Function
REQ-012 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
REQ-013 FETCH: memRead=1; on mem_ready -> ir_write=1 that cycle, next DECODE; else stay.
REQ-014 DECODE: latch inst[6:0] into op_q and inst[14:12], inst[20] into sys_q; next EXEC; no strobes asserted.
REQ-015 EXEC: ALUOp/ALUSrc per op_q (LUI/AUIPC/Load/Store/JALR: 00/1; JAL: 10/1; Branch: 01/0; Arith_I: 11/1; Arith_R: 10/0).
REQ-016 EXEC transitions: Load/Store -> MEM; Branch -> FETCH with branch=1, pc_write=1; LUI/AUIPC/JAL/JALR/Arith -> WB.
REQ-017 EXEC with SYSTEM, funct3=000, inst[20]=1 (EBREAK) -> HALT, pc_write=0; any other SYSTEM, FENCE or unknown opcode -> FETCH with pc_write=1 only (no-op).
REQ-018 MEM: Load asserts memRead, Store asserts memWrite, ALUOp=00, ALUSrc=1, held until mem_ready; Load -> WB; Store -> FETCH with pc_write=1 in the mem_ready cycle.
REQ-019 WB: regWrite=1, pc_write=1; memToReg 001 Load, 010 LUI, 011 AUIPC, 100 JAL/JALR, 000 Arith; branch=1 for JAL/JALR only; next FETCH.
REQ-020 HALT: ebreak_signal=1, all other strobes 0; resume=1 -> FETCH with pc_write=1 (PC advances past EBREAK).
REQ-021 Wait counter SHALL clear on every state entry and increment each FETCH/MEM cycle with mem_ready=0.
REQ-022 Counter = 2^TIMEOUT_W-1 with mem_ready=0 -> ERROR; mem_ready=1 in that same cycle wins (normal completion).
REQ-023 ERROR: mem_err=1, all strobes 0; exit only by reset.
REQ-024 Any output not listed for a state SHALL be 0; each instruction causes exactly one pc_write pulse, except EBREAK, whose pc_write occurs on resume.
REQ-025 Outputs SHALL be combinational from state, op_q, sys_q and mem_ready; no glitch-sensitive outputs beyond these.

Reset
REQ-026 rst=1 SHALL asynchronously set state=FETCH, counter=0, op_q=0, sys_q=0, mem_err=0.
REQ-027 While rst=1, all outputs SHALL be 0 (state reads 0); first memRead asserts in the first cycle after rst deasserts.
REQ-028 Reset mid-instruction (any state, including HALT/ERROR) SHALL abandon it with no further strobes.

Verification
REQ-029 R-type 0x002081B3, mem_ready=1 in FETCH -> states 0,1,2,4,0; WB cycle regWrite=1, memToReg=000, pc_write=1; 4 cycles/instruction.
REQ-030 Load 0x0000A103, mem_ready low 3 cycles in MEM -> memRead held 4 MEM cycles, then WB memToReg=001, regWrite=1.
REQ-031 Store 0x0020A023 -> MEM memWrite=1, pc_write=1 on ready cycle, regWrite never 1, back to FETCH.
REQ-032 BEQ 0x00208463 -> EXEC ALUOp=01, ALUSrc=0, branch=1, pc_write=1; next state FETCH.
REQ-033 EBREAK 0x00100073 -> HALT with ebreak_signal=1 for 10 cycles; resume pulse -> pc_write=1, FETCH.
REQ-034 TIMEOUT_W=4, mem_ready held 0 in FETCH -> ERROR after 15 wait cycles, mem_err=1 until rst; repeat with mem_ready=1 on cycle 15 -> DECODE, no error.
